sha3_scan_lane_scheduler: RTL and testbench

- Accepts one mining job (block template, threshold, base extranonce) and fans it out to N_LANES sha3 scanner lanes.
- Each lane gets the same template with the extranonce word replaced by base+lane index, so lanes search disjoint spaces.
- Monitors lane completion and arbitrates the first winning lane (lowest index on ties).
- Aborts the remaining lanes, then returns one result record upstream. Sits between the host job interface and the scanner array.

---
 rtl/sha3_scan_lane_scheduler_pkg.sv | 24 ++
 rtl/sha3_scan_lane_scheduler_if.sv | 31 +++
 rtl/sha3_lane_priority_pick.sv | 21 ++
 rtl/sha3_scan_lane_scheduler.sv | 155 +++++++++++++++
 tb/tb_sha3_scan_lane_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_scan_lane_scheduler_pkg.sv
// Shared constants, FSM encoding and result record for the sha3 lane scheduler.
package sha3_scan_sched_pkg;

   localparam int unsigned TEMPLATE_WORDS = 24;
   localparam int unsigned TEMPLATE_W     = 768;
   localparam int unsigned LANE_MAX_W     = 4;

   typedef logic [4:0] state_t;

   localparam state_t ST_IDLE    = 5'b00001;
   localparam state_t ST_LAUNCH  = 5'b00010;
   localparam state_t ST_RUNNING = 5'b00100;
   localparam state_t ST_ABORT   = 5'b01000;
   localparam state_t ST_REPORT  = 5'b10000;

   typedef struct packed {
      logic                  found;
      logic                  timeout;
      logic [LANE_MAX_W-1:0] lane;
      logic [31:0]           extranonce;
      logic [31:0]           nonce;
   } sched_result_t;

endpackage

// File: rtl/sha3_scan_lane_scheduler_if.sv
// Host-side job and result handshakes of the lane scheduler.
interface sha3_scan_lane_scheduler_if #(
   parameter int unsigned LANE_W = 2
);
   import sha3_scan_sched_pkg::*;

   logic                  job_valid;
   logic                  job_ready;
   logic [TEMPLATE_W-1:0] job_template;
   logic [63:0]           job_threshold;
   logic [31:0]           job_extranonce;

   logic                  res_valid;
   logic                  res_ready;
   logic                  res_found;
   logic                  res_timeout;
   logic [LANE_W-1:0]     res_lane;
   logic [31:0]           res_extranonce;
   logic [31:0]           res_nonce;

   modport master (
      output job_valid, job_template, job_threshold, job_extranonce, res_ready,
      input  job_ready, res_valid, res_found, res_timeout, res_lane, res_extranonce, res_nonce
   );

   modport slave (
      input  job_valid, job_template, job_threshold, job_extranonce, res_ready,
      output job_ready, res_valid, res_found, res_timeout, res_lane, res_extranonce, res_nonce
   );

endinterface

// File: rtl/sha3_lane_priority_pick.sv
// Lowest-index-first encoder: returns the index of the lowest set request bit.
module sha3_lane_priority_pick #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan downwards so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/sha3_scan_lane_scheduler.sv
// Fans one mining job out to N_LANES sha3 scanners, picks the first winner,
// aborts the rest and returns a single result record.
module sha3_scan_lane_scheduler
   import sha3_scan_sched_pkg::*;
#(
   parameter int unsigned N_LANES         = 4,
   parameter int unsigned LANE_W          = (N_LANES > 1) ? $clog2(N_LANES) : 1,
   parameter int unsigned EXTRANONCE_WORD = 22,
   parameter int unsigned TIMEOUT_CYCLES  = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   sha3_scan_lane_scheduler_if.slave     host,
   output logic [N_LANES-1:0]            lane_start,
   output logic [N_LANES*TEMPLATE_W-1:0] lane_template,
   output logic [63:0]                   lane_threshold,
   output logic [N_LANES-1:0]            lane_abort,
   input  logic [N_LANES-1:0]            lane_ready,
   input  logic [N_LANES-1:0]            lane_found,
   input  logic [N_LANES*32-1:0]         lane_nonce
);

   localparam logic [31:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   state_t                state_q, state_d;
   logic [TEMPLATE_W-1:0] tmpl_q, tmpl_d;
   logic [63:0]           thr_q, thr_d;
   logic [31:0]           ext_q, ext_d;
   logic [31:0]           wd_q, wd_d;
   logic                  guard_q, guard_d;
   sched_result_t         res_q, res_d;

   logic [LANE_W-1:0]     pick_idx;
   logic                  pick_valid;
   logic [31:0]           win_nonce;
   logic                  all_ready;
   logic                  wd_expired;
   logic                  unused_lane;

   sha3_lane_priority_pick #(
      .N (N_LANES),
      .W (LANE_W)
   ) u_pick (
      .req   (lane_found),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      win_nonce = '0;
      for (int k = 0; k < N_LANES; k++) begin
         if (pick_idx == LANE_W'(k)) win_nonce = lane_nonce[k*32 +: 32];
      end
   end

   assign all_ready  = &lane_ready;
   assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LIMIT);

   always_comb begin
      state_d = state_q;
      tmpl_d  = tmpl_q;
      thr_d   = thr_q;
      ext_d   = ext_q;
      wd_d    = wd_q;
      guard_d = guard_q;
      res_d   = res_q;
      unique case (state_q)
         ST_IDLE: begin
            if (host.job_valid) begin
               tmpl_d  = host.job_template;
               thr_d   = host.job_threshold;
               ext_d   = host.job_extranonce;
               wd_d    = '0;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (all_ready) begin
               guard_d = 1'b1;
               state_d = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            guard_d = 1'b0;
            if (wd_q != '1) wd_d = wd_q + 32'd1;
            // Lanes are still dropping lane_ready in the guard cycle, so exhaustion waits.
            if (pick_valid) begin
               res_d.found      = 1'b1;
               res_d.timeout    = 1'b0;
               res_d.lane       = LANE_MAX_W'(pick_idx);
               res_d.extranonce = ext_q + 32'(pick_idx);
               res_d.nonce      = win_nonce;
               state_d          = ST_ABORT;
            end else if (!guard_q && all_ready) begin
               res_d   = '0;
               state_d = ST_REPORT;
            end else if (wd_expired) begin
               res_d         = '0;
               res_d.timeout = 1'b1;
               state_d       = ST_ABORT;
            end
         end
         ST_ABORT: begin
            if (all_ready) state_d = ST_REPORT;
         end
         ST_REPORT: begin
            if (host.res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tmpl_q  <= '0;
         thr_q   <= '0;
         ext_q   <= '0;
         wd_q    <= '0;
         guard_q <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         tmpl_q  <= tmpl_d;
         thr_q   <= thr_d;
         ext_q   <= ext_d;
         wd_q    <= wd_d;
         guard_q <= guard_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      lane_template = '0;
      for (int k = 0; k < N_LANES; k++) begin
         lane_template[k*TEMPLATE_W +: TEMPLATE_W] = tmpl_q;
         lane_template[k*TEMPLATE_W + EXTRANONCE_WORD*32 +: 32] = ext_q + 32'(k);
      end
   end

   assign lane_start     = {N_LANES{(state_q == ST_LAUNCH) && all_ready}};
   assign lane_abort     = {N_LANES{state_q == ST_ABORT}};
   assign lane_threshold = thr_q;

   assign host.job_ready      = (state_q == ST_IDLE);
   assign host.res_valid      = (state_q == ST_REPORT);
   assign host.res_found      = res_q.found;
   assign host.res_timeout    = res_q.timeout;
   assign host.res_lane       = res_q.lane[LANE_W-1:0];
   assign host.res_extranonce = res_q.extranonce;
   assign host.res_nonce      = res_q.nonce;

   assign unused_lane = ^res_q.lane;

endmodule

// File: tb/tb_sha3_scan_lane_scheduler.sv
// Scenario bench for sha3_scan_lane_scheduler with a behavioural lane/result model.
module tb_sha3_scan_lane_scheduler;
   import sha3_scan_sched_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned LW = 2;
   localparam int unsigned XW = 22;
   localparam int unsigned TO = 100;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic [N-1:0]            lane_start;
   logic [N*TEMPLATE_W-1:0] lane_template;
   logic [63:0]             lane_threshold;
   logic [N-1:0]            lane_abort;
   logic [N-1:0]            lane_ready;
   logic [N-1:0]            lane_found;
   logic [N*32-1:0]         lane_nonce;

   int checks   = 0;
   int failures = 0;

   logic [31:0] tmpl_words [TEMPLATE_WORDS];
   logic [63:0] cur_thr;
   logic [31:0] cur_ext;

   sha3_scan_lane_scheduler_if #(.LANE_W(LW)) hif ();

   sha3_scan_lane_scheduler #(
      .N_LANES         (N),
      .LANE_W          (LW),
      .EXTRANONCE_WORD (XW),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .host           (hif),
      .lane_start     (lane_start),
      .lane_template  (lane_template),
      .lane_threshold (lane_threshold),
      .lane_abort     (lane_abort),
      .lane_ready     (lane_ready),
      .lane_found     (lane_found),
      .lane_nonce     (lane_nonce)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected template: captured words, with the extranonce word set to base + lane.
   task automatic check_templates(input string name);
      logic        bad;
      logic [31:0] got, exp;
      for (int k = 0; k < N; k++) begin
         bad = 1'b0;
         for (int w = 0; w < TEMPLATE_WORDS; w++) begin
            exp = (w == XW) ? cur_ext + 32'(k) : tmpl_words[w];
            got = lane_template[(k*TEMPLATE_WORDS + w)*32 +: 32];
            if (got !== exp && !bad) begin
               bad = 1'b1;
               $display("FAIL %s lane%0d word%0d got=%h exp=%h", name, k, w, got, exp);
            end
         end
         checks++;
         if (bad) failures++;
      end
   endtask

   task automatic check_reset_state(input string name);
      checks++;
      if (hif.job_ready !== 1'b1) begin
         failures++; $display("FAIL %s_job_ready got=%b exp=1", name, hif.job_ready);
      end
      checks++;
      if ({hif.res_valid, hif.res_found, hif.res_timeout} !== 3'b000) begin
         failures++; $display("FAIL %s_res_flags got=%b exp=000", name,
                              {hif.res_valid, hif.res_found, hif.res_timeout});
      end
      checks++;
      if ({hif.res_lane, hif.res_extranonce, hif.res_nonce} !== '0) begin
         failures++; $display("FAIL %s_res_fields got=%h/%h/%h exp=0", name,
                              hif.res_lane, hif.res_extranonce, hif.res_nonce);
      end
      checks++;
      if ({lane_start, lane_abort} !== '0) begin
         failures++; $display("FAIL %s_lane_ctl got=%b/%b exp=0", name, lane_start, lane_abort);
      end
      checks++;
      if (lane_threshold !== 64'd0) begin
         failures++; $display("FAIL %s_threshold got=%h exp=0", name, lane_threshold);
      end
      for (int w = 0; w < TEMPLATE_WORDS; w++) tmpl_words[w] = 32'd0;
      cur_ext = 32'd0;
      check_templates({name, "_template"});
   endtask

   // Offers a random-template job, then plays the lanes through LAUNCH into the guard cycle.
   task automatic start_job(input logic [31:0] ext, input logic [N-1:0] ready_at_accept);
      int n;
      for (int w = 0; w < TEMPLATE_WORDS; w++) begin
         tmpl_words[w] = $urandom;
         hif.job_template[w*32 +: 32] = tmpl_words[w];
      end
      cur_thr = {$urandom, $urandom};
      cur_ext = ext;
      hif.job_threshold  = cur_thr;
      hif.job_extranonce = ext;
      hif.job_valid      = 1'b1;
      lane_ready         = ready_at_accept;
      lane_found         = '0;
      n = 0;
      while (hif.job_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (hif.job_ready !== 1'b1) begin
         failures++; $display("FAIL job_ready_wait got=%b exp=1", hif.job_ready);
      end
      tick();
      hif.job_valid      = 1'b0;
      hif.job_template   = {24{$urandom}};
      hif.job_extranonce = $urandom;
      hif.job_threshold  = {$urandom, $urandom};
      #1;
      checks++;
      if (lane_threshold !== cur_thr) begin
         failures++; $display("FAIL threshold_capture got=%h exp=%h", lane_threshold, cur_thr);
      end
      check_templates("lane_template");
      if (ready_at_accept != '1) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (lane_start !== '0) begin
               failures++; $display("FAIL launch_wait_start got=%b exp=0000", lane_start);
            end
            tick();
         end
         lane_ready = '1;
         #1;
      end
      checks++;
      if (lane_start !== '1) begin
         failures++; $display("FAIL lane_start_pulse got=%b exp=1111", lane_start);
      end
      tick();
      lane_ready = '0;
      #1;
      checks++;
      if (lane_start !== '0) begin
         failures++; $display("FAIL lane_start_one_cycle got=%b exp=0000", lane_start);
      end
   endtask

   task automatic run_busy(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         checks++;
         if ({lane_abort, hif.res_valid} !== '0) begin
            failures++; $display("FAIL running_quiet cyc%0d got=%b/%b exp=0", i, lane_abort,
                                 hif.res_valid);
         end
         tick();
      end
   endtask

   task automatic expect_result(input logic ef, input logic et, input logic [LW-1:0] el,
                                input logic [31:0] ee, input logic [31:0] en, input int hold);
      int n;
      hif.res_ready = 1'b0;
      n = 0;
      while (hif.res_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (hif.res_valid !== 1'b1) begin
         failures++; $display("FAIL res_valid_wait got=%b exp=1", hif.res_valid);
      end
      for (int h = 0; h <= hold; h++) begin
         checks++;
         if ({hif.res_found, hif.res_timeout} !== {ef, et}) begin
            failures++; $display("FAIL res_flags h%0d got=%b%b exp=%b%b", h, hif.res_found,
                                 hif.res_timeout, ef, et);
         end
         if (ef) begin
            checks++;
            if ({hif.res_lane, hif.res_extranonce, hif.res_nonce} !== {el, ee, en}) begin
               failures++; $display("FAIL res_fields h%0d got=%0d/%h/%h exp=%0d/%h/%h", h,
                                    hif.res_lane, hif.res_extranonce, hif.res_nonce, el, ee, en);
            end
         end
         checks++;
         if ({hif.job_ready, hif.res_valid} !== 2'b01) begin
            failures++; $display("FAIL report_hold h%0d got=%b%b exp=01", h, hif.job_ready,
                                 hif.res_valid);
         end
         if (h < hold) tick();
      end
      hif.res_ready = 1'b1;
      tick();
      hif.res_ready = 1'b0;
      checks++;
      if ({hif.res_valid, hif.job_ready} !== 2'b01) begin
         failures++; $display("FAIL res_release got=%b%b exp=01", hif.res_valid, hif.job_ready);
      end
   endtask

   task automatic run_found(input logic [31:0] ext, input int wait_cyc, input logic [N-1:0] fvec,
                            input logic [N*32-1:0] nonces, input int hold);
      int k;
      k = 0;
      while (k < N - 1 && !fvec[k]) k++;
      start_job(ext, '1);
      run_busy(wait_cyc);
      lane_found = fvec;
      lane_nonce = nonces;
      tick();
      // Late finders and changing nonces must not disturb the captured winner.
      lane_found = '1;
      lane_nonce = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({lane_abort, hif.res_valid} !== {4'b1111, 1'b0}) begin
            failures++; $display("FAIL abort_held cyc%0d got=%b/%b exp=1111/0", i, lane_abort,
                                 hif.res_valid);
         end
         tick();
      end
      lane_ready = '1;
      tick();
      checks++;
      if (lane_abort !== '0) begin
         failures++; $display("FAIL abort_release got=%b exp=0000", lane_abort);
      end
      expect_result(1'b1, 1'b0, LW'(k), ext + 32'(k), nonces[k*32 +: 32], hold);
      lane_found = '0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      check_reset_state("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_launch_wait();
      start_job($urandom, 4'b0111);
      run_busy(4);
      lane_ready = '1;
      tick();
      expect_result(1'b0, 1'b0, '0, 32'd0, 32'd0, 0);
   endtask

   task automatic test_found_basic();
      logic [N*32-1:0] nonces;
      nonces = {$urandom, $urandom, $urandom, $urandom};
      nonces[2*32 +: 32] = 32'h1234;
      run_found(32'h100, 50, 4'b0100, nonces, 0);
   endtask

   task automatic test_tie();
      run_found($urandom, 7, 4'b1010, {$urandom, $urandom, $urandom, $urandom}, 0);
   endtask

   task automatic test_found_random();
      for (int i = 0; i < 6; i++) begin
         run_found($urandom, int'($urandom_range(0, 80)), 4'($urandom_range(1, 15)),
                   {$urandom, $urandom, $urandom, $urandom}, 0);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w [N];
      logic [31:0] got;
      exp_w[0] = 32'hFFFF_FFFE;
      exp_w[1] = 32'hFFFF_FFFF;
      exp_w[2] = 32'h0000_0000;
      exp_w[3] = 32'h0000_0001;
      start_job(32'hFFFF_FFFE, '1);
      for (int k = 0; k < N; k++) begin
         got = lane_template[(k*TEMPLATE_WORDS + XW)*32 +: 32];
         checks++;
         if (got !== exp_w[k]) begin
            failures++; $display("FAIL wrap_word lane%0d got=%h exp=%h", k, got, exp_w[k]);
         end
      end
      lane_found = 4'b1000;
      lane_nonce = 128'h0000_00AA_0000_0000_0000_0000_0000_0000;
      tick();
      lane_ready = '1;
      tick();
      expect_result(1'b1, 1'b0, 2'd3, 32'h0000_0001, 32'h0000_00AA, 0);
      lane_found = '0;
   endtask

   task automatic test_guard();
      start_job($urandom, '1);
      lane_ready = '1;
      tick();
      lane_ready = '0;
      checks++;
      if (hif.res_valid !== 1'b0) begin
         failures++; $display("FAIL guard_ignored got=%b exp=0", hif.res_valid);
      end
      run_busy(5);
      lane_ready = '1;
      tick();
      expect_result(1'b0, 1'b0, '0, 32'd0, 32'd0, 0);
   endtask

   task automatic test_exhausted();
      start_job($urandom, '1);
      run_busy(int'($urandom_range(3, 60)));
      lane_ready = '1;
      tick();
      checks++;
      if (lane_abort !== '0) begin
         failures++; $display("FAIL exhausted_no_abort got=%b exp=0000", lane_abort);
      end
      expect_result(1'b0, 1'b0, '0, 32'd0, 32'd0, 0);
   endtask

   task automatic test_timeout();
      start_job($urandom, '1);
      run_busy(TO);
      checks++;
      if ({lane_abort, hif.res_valid} !== {4'b1111, 1'b0}) begin
         failures++; $display("FAIL timeout_abort got=%b/%b exp=1111/0", lane_abort,
                              hif.res_valid);
      end
      tick();
      tick();
      lane_ready = '1;
      tick();
      expect_result(1'b0, 1'b1, '0, 32'd0, 32'd0, 0);
   endtask

   task automatic test_hold_and_reset();
      run_found($urandom, 20, 4'($urandom_range(1, 15)),
                {$urandom, $urandom, $urandom, $urandom}, 10);
      start_job($urandom, '1);
      run_busy(5);
      rst_n = 1'b0;
      #1;
      check_reset_state("reset_running");
      tick();
      rst_n = 1'b1;
      lane_ready = '1;
      tick();
      start_job($urandom, '1);
      lane_found = 4'b0001;
      tick();
      checks++;
      if (lane_abort !== '1) begin
         failures++; $display("FAIL abort_before_reset got=%b exp=1111", lane_abort);
      end
      rst_n = 1'b0;
      #1;
      check_reset_state("reset_abort");
      lane_found = '0;
      lane_ready = '1;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      hif.job_valid      = 1'b0;
      hif.job_template   = '0;
      hif.job_threshold  = '0;
      hif.job_extranonce = '0;
      hif.res_ready      = 1'b0;
      lane_ready         = '1;
      lane_found         = '0;
      lane_nonce         = '0;
      test_reset();
      test_launch_wait();
      test_found_basic();
      test_tie();
      test_found_random();
      test_wrap();
      test_guard();
      test_exhausted();
      test_timeout();
      test_hold_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL global_watchdog got=running exp=finished");
      $fatal(1, "simulation did not finish");
   end

endmodule
